// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and its detector.
// Holds the FSM state encoding, the 0011_1000 marker pattern and the idle line level.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    PAR   = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  // Plain vector copies of the state encoding for code that keeps state in logic vectors.
  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_SHIFT = SHIFT;
  localparam logic [2:0] ST_PAR   = PAR;
  localparam logic [2:0] ST_GAP   = GAP;
  localparam logic [2:0] ST_DONE  = DONE;

  localparam logic [7:0] PAT_38   = 8'b0011_1000;
  localparam logic       SEQ_IDLE = 1'b1;

endpackage

// File: rtl/seq_gen_38.sv
// Serial pattern generator: sends an 8-bit pattern (default marker or a user
// pattern) MSB first on dout, repeated rep times, each frame followed by an idle gap.
// Optional build macro SEQ_GEN_PARITY_EN appends one even-parity bit per frame.
// Outputs are flops loaded from next-state values, so each output already
// reflects the state that is entered at the same edge.
module seq_gen_38
  import seq_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] DEFAULT_PAT = PAT_38,
  parameter int               GAP_LEN     = 1,
  parameter int               REP_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             use_dflt,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [REP_W-1:0] rep,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic             frame_end,
  output logic [2:0]       state
);

  localparam int               BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]    BIT_LAST = BW'(WIDTH - 1);
  localparam logic [3:0]       GAP_LAST = 4'(GAP_LEN - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             frame_end_q, frame_end_d;

  // Next-state logic: FSM transitions plus shift register and counter updates.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    pat_d     = pat_q;
    rep_cnt_d = rep_cnt_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Latch the pattern once; later pat_in/rep changes must not disturb the run.
          pat_d     = use_dflt ? DEFAULT_PAT : pat_in;
          sr_d      = use_dflt ? DEFAULT_PAT : pat_in;
          rep_cnt_d = (rep == '0) ? REP_ONE : rep;
          bit_cnt_d = BIT_LAST;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
        if (bit_cnt_q == '0) begin
`ifdef SEQ_GEN_PARITY_EN
          state_d   = ST_PAR;
`else
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LAST;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      ST_PAR: begin
        state_d   = ST_GAP;
        gap_cnt_d = GAP_LAST;
      end
`endif
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          rep_cnt_d = rep_cnt_q - 1'b1;
          // A count of one before the decrement means this was the last frame.
          if (rep_cnt_q != REP_ONE) begin
            sr_d      = pat_q;
            bit_cnt_d = BIT_LAST;
            state_d   = ST_SHIFT;
          end else begin
            state_d   = ST_DONE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, registered below alongside the state.
  always_comb begin
    dout_d      = SEQ_IDLE;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    frame_end_d = 1'b0;
    case (state_d)
      ST_SHIFT: begin
        dout_d = sr_d[WIDTH-1];
        busy_d = 1'b1;
`ifndef SEQ_GEN_PARITY_EN
        frame_end_d = (bit_cnt_d == '0);
`endif
      end
`ifdef SEQ_GEN_PARITY_EN
      ST_PAR: begin
        dout_d      = ^pat_d;
        busy_d      = 1'b1;
        frame_end_d = 1'b1;
      end
`endif
      ST_GAP:  busy_d = 1'b1;
      ST_DONE: done_d = 1'b1;
      default: dout_d = SEQ_IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      pat_q       <= '0;
      rep_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      dout_q      <= SEQ_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      pat_q       <= pat_d;
      rep_cnt_q   <= rep_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign dout      = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_end = frame_end_q;
  assign state     = state_q;

endmodule

// File: tb/tb_seq_gen_38.sv
// Testbench for seq_gen_38: a queue-based model expands each accepted start
// into the expected per-cycle output tuples; every cycle is compared against it.
module tb_seq_gen_38;

`ifdef SEQ_GEN_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int GAP_LEN = 1;
  localparam int F       = 8 + P + GAP_LEN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       use_dflt = 1'b0;
  logic [7:0] pat_in = 8'h00;
  logic [3:0] rep = 4'd0;
  logic       dout, busy, done, frame_end;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  // Expected tuple per cycle: {dout, busy, done, frame_end, state[2:0]}
  logic [6:0] q[$];
  localparam logic [6:0] IDLE_T = 7'b1000000;

  seq_gen_38 #(.WIDTH(8), .DEFAULT_PAT(8'b0011_1000), .GAP_LEN(GAP_LEN), .REP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .use_dflt(use_dflt), .pat_in(pat_in),
    .rep(rep), .dout(dout), .busy(busy), .done(done), .frame_end(frame_end), .state(state)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expand one accepted request into its full cycle-by-cycle expectation.
  task automatic model_push(input logic ud, input logic [7:0] pin, input logic [3:0] rp);
    int n;
    logic [7:0] p;
    n = (rp == 0) ? 1 : int'(rp);
    p = ud ? 8'b0011_1000 : pin;
    for (int f = 0; f < n; f++) begin
      for (int i = 7; i >= 0; i--)
        q.push_back({p[i], 1'b1, 1'b0, (i == 0 && P == 0), 3'd1});
      if (P == 1) q.push_back({^p, 1'b1, 1'b0, 1'b1, 3'd2});
      for (int g = 0; g < GAP_LEN; g++) q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 3'd3});
    end
    q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 3'd4});
  endtask

  task automatic run_tx(input logic ud, input logic [7:0] pat, input logic [3:0] rp,
                        input int disturb, input logic poke_done,
                        output int bn, output logic [63:0] bits, output logic [63:0] fe,
                        output int dn);
    bn = 0; bits = '0; fe = '0; dn = 0;
    @(posedge clk); #1;
    start = 1'b1; use_dflt = ud; pat_in = pat; rep = rp;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 600 && dn == 0; c++) begin
      @(negedge clk);
      if (busy) begin
        bits = {bits[62:0], dout};
        if (frame_end && bn < 64) fe[bn] = 1'b1;
        bn++;
      end
      if (done) begin
        dn++;
        if (poke_done) start = 1'b1;
      end else if (busy && bn == disturb) begin
        start = 1'b1; pat_in = ~pat; rep = rp + 4'd1; use_dflt = ~ud;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("run_done", 64'(dn), 64'd1);
    $display("[TB] tx use_dflt=%0d pat=%02h rep=%0d busy_cycles=%0d done=%0d", ud, pat, rp, bn, dn);
  endtask

  initial begin
    int bn, dn;
    logic [63:0] bits, fe, e_bits, e_fe;
    logic [7:0] rp8;

    // Reference model: advances one expected tuple per clock, or accepts a start when idle.
    fork
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) q.delete();
        else if (q.size() != 0) void'(q.pop_front());
        else if (start) model_push(use_dflt, pat_in, rep);
      end
      forever begin
        @(negedge clk);
        chk("cycle", 64'({dout, busy, done, frame_end, state}),
            64'((q.size() != 0) ? q[0] : IDLE_T));
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 64'({dout, busy, done, frame_end, state}), 64'(IDLE_T));
    @(posedge clk); #1 rst_n = 1'b1;

    // Default marker, single frame
    run_tx(1'b1, 8'hFF, 4'd1, -1, 1'b0, bn, bits, fe, dn);
    chk("t1_busy", 64'(bn), 64'(9 + P));
`ifdef SEQ_GEN_PARITY_EN
    e_bits = 64'b00111000_1_1;
`else
    e_bits = 64'b00111000_1;
`endif
    chk("t1_bits", bits, e_bits);

    // User pattern A5, three frames
    run_tx(1'b0, 8'hA5, 4'd3, -1, 1'b0, bn, bits, fe, dn);
    chk("t2_busy", 64'(bn), 64'(3 * F));
`ifdef SEQ_GEN_PARITY_EN
    e_bits = {34'd0, 10'b10100101_0_1, 10'b10100101_0_1, 10'b10100101_0_1};
    e_fe   = (64'd1 << 8) | (64'd1 << 18) | (64'd1 << 28);
`else
    e_bits = {37'd0, 9'b10100101_1, 9'b10100101_1, 9'b10100101_1};
    e_fe   = (64'd1 << 7) | (64'd1 << 16) | (64'd1 << 25);
`endif
    chk("t2_bits", bits, e_bits);
    chk("t2_frame_end", fe, e_fe);

    // rep = 0 behaves as rep = 1
    run_tx(1'b1, 8'h00, 4'd0, -1, 1'b0, bn, bits, fe, dn);
    chk("t3_busy", 64'(bn), 64'(F));

    // start and pat_in changed mid-frame are ignored; start in DONE cycle ignored
    run_tx(1'b0, 8'hC3, 4'd1, 4, 1'b1, bn, bits, fe, dn);
`ifdef SEQ_GEN_PARITY_EN
    e_bits = 64'b11000011_0_1;
`else
    e_bits = 64'b11000011_1;
`endif
    chk("t4_bits", bits, e_bits);
    chk("t4_busy", 64'(bn), 64'(F));

    // Asynchronous reset at bit 5 aborts the frame
    @(posedge clk); #1 start = 1'b1; use_dflt = 1'b1; rep = 4'd2;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("t5_async_rst", 64'({dout, busy, done, frame_end, state}), 64'(IDLE_T));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run_tx(1'b1, 8'h00, 4'd1, -1, 1'b0, bn, bits, fe, dn);
    chk("t5_after_busy", 64'(bn), 64'(9 + P));
`ifdef SEQ_GEN_PARITY_EN
    e_bits = 64'b00111000_1_1;
`else
    e_bits = 64'b00111000_1;
`endif
    chk("t5_after_bits", bits, e_bits);

    // Randomized transactions with random disturbances
    for (int t = 0; t < 25; t++) begin
      rp8 = 8'($urandom_range(0, 4));
      run_tx(1'($urandom_range(0, 1)), 8'($urandom), rp8[3:0],
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1,
             1'($urandom_range(0, 1)), bn, bits, fe, dn);
      chk("rnd_busy", 64'(bn), 64'(((rp8 == 0) ? 1 : int'(rp8)) * F));
    end

    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
